// File: rtl/param_counter.sv
// Parametrised up/down counter with prescaler, synchronous load, wrap or saturate
// at the bounds, a one-cycle terminal pulse per bounded step, and a registered compare match.
module param_counter #(
    parameter int WIDTH    = 8,
    parameter int TAP      = 2,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] compare,
    output logic [WIDTH-1:0] count,
    output logic             out1,
    output logic             terminal,
    output logic             match
);

    localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic             step;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             terminal_reg;
    logic             terminal_next;
    logic             match_reg;

    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] prescale_reg;

            assign step = enable && !load && (prescale_reg == LAST);

            // Load restarts the prescale window; a disabled cycle freezes it mid-count.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    prescale_reg <= '0;
                end else if (load || step) begin
                    prescale_reg <= '0;
                end else if (enable) begin
                    prescale_reg <= prescale_reg + PW'(1);
                end
            end
        end else begin : g_no_prescale
            assign step = enable && !load;
        end
    endgenerate

    always_comb begin
        count_next    = count_reg;
        terminal_next = 1'b0;
        if (load) begin
            count_next = load_value;
        end else if (step) begin
            if (up) begin
                if (count_reg == MAX_VAL) begin
                    terminal_next = 1'b1;
                    if (SATURATE == 0) count_next = '0;
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
            end else begin
                if (count_reg == '0) begin
                    terminal_next = 1'b1;
                    if (SATURATE == 0) count_next = MAX_VAL;
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end
        end
    end

    // match tracks the value count takes at this edge, so it lines up with count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg    <= '0;
            terminal_reg <= 1'b0;
            match_reg    <= 1'b0;
        end else begin
            count_reg    <= count_next;
            terminal_reg <= terminal_next;
            match_reg    <= (count_next == compare);
        end
    end

    assign count    = count_reg;
    assign out1     = count_reg[TAP];
    assign terminal = terminal_reg;
    assign match    = match_reg;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: three instances (defaults, PRESCALE=3, SATURATE=1),
// directed stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_param_counter;

    logic       clock;
    logic       rst;
    logic       en     [3];
    logic       up_s   [3];
    logic       ld     [3];
    logic [7:0] lv     [3];
    logic [7:0] cmp    [3];
    logic [7:0] cnt    [3];
    logic       o1     [3];
    logic       term   [3];
    logic       mt     [3];

    int tests_run = 0;
    int tests_failed = 0;
    int edge_cnt = 0;

    typedef struct {
        int         edge_no;
        int         id;
        int         tag;
        logic [7:0] cnt;
        logic       term;
        logic       mt;
    } exp_t;

    exp_t sb_q[$];

    param_counter #(.WIDTH(8), .TAP(2), .PRESCALE(1), .SATURATE(0)) u_def (
        .clock(clock), .reset(rst), .enable(en[0]), .up(up_s[0]), .load(ld[0]),
        .load_value(lv[0]), .compare(cmp[0]), .count(cnt[0]), .out1(o1[0]),
        .terminal(term[0]), .match(mt[0])
    );

    param_counter #(.WIDTH(8), .TAP(2), .PRESCALE(3), .SATURATE(0)) u_pre (
        .clock(clock), .reset(rst), .enable(en[1]), .up(up_s[1]), .load(ld[1]),
        .load_value(lv[1]), .compare(cmp[1]), .count(cnt[1]), .out1(o1[1]),
        .terminal(term[1]), .match(mt[1])
    );

    param_counter #(.WIDTH(8), .TAP(2), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clock(clock), .reset(rst), .enable(en[2]), .up(up_s[2]), .load(ld[2]),
        .load_value(lv[2]), .compare(cmp[2]), .count(cnt[2]), .out1(o1[2]),
        .terminal(term[2]), .match(mt[2])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int tag, input logic [7:0] c,
                        input logic t, input logic m);
        exp_t e;
        e.edge_no = edge_cnt + 1;
        e.id      = id;
        e.tag     = tag;
        e.cnt     = c;
        e.term    = t;
        e.mt      = m;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every cycle, retire the expectations scheduled for the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #3;
            while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
                e = sb_q.pop_front();
                if (e.edge_no != edge_cnt) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL t%0d stale entry: edge %0d, now %0d", e.tag, e.edge_no, edge_cnt);
                end else begin
                    check($sformatf("t%0d dut%0d count", e.tag, e.id), 32'(cnt[e.id]), 32'(e.cnt));
                    check($sformatf("t%0d dut%0d out1", e.tag, e.id), 32'(o1[e.id]), 32'(e.cnt[2]));
                    check($sformatf("t%0d dut%0d terminal", e.tag, e.id), 32'(term[e.id]), 32'(e.term));
                    check($sformatf("t%0d dut%0d match", e.tag, e.id), 32'(mt[e.id]), 32'(e.mt));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] en_pat;
        logic [11:0] mt_pat;
        logic [7:0]  exp2 [12];
        logic [7:0]  c;

        en_pat = 12'b1110_0111_1111;
        mt_pat = 12'b1100_0000_0000;
        exp2   = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; up_s[k] = 1'b1; ld[k] = 1'b0; lv[k] = 8'h00; cmp[k] = 8'h00;
        end
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset dut%0d count", k), 32'(cnt[k]), 32'h0);
            check($sformatf("reset dut%0d terminal", k), 32'(term[k]), 32'h0);
            check($sformatf("reset dut%0d match", k), 32'(mt[k]), 32'h0);
        end
        rst = 1'b0;

        // Test 1: free-running up count on the default instance.
        en[0] = 1'b1; up_s[0] = 1'b1; cmp[0] = 8'h80;
        for (int i = 0; i < 300; i++) begin
            c = 8'((i + 1) & 255);
            push(0, 1, c, ((i & 255) == 255), (c == 8'h80));
            cyc();
        end
        en[0] = 1'b0;
        push(0, 1, 8'h2C, 1'b0, 1'b0);
        cyc();

        // Test 2: prescale by 3 with enable dropped for two cycles mid-window.
        cmp[1] = 8'h03; up_s[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            en[1] = en_pat[i];
            push(1, 2, exp2[i], 1'b0, mt_pat[i]);
            cyc();
        end
        en[1] = 1'b0;

        // Test 3: saturating at max, then stepping back down.
        cmp[2] = 8'hFF; ld[2] = 1'b1; lv[2] = 8'hFE;
        push(2, 3, 8'hFE, 1'b0, 1'b0);
        cyc();
        ld[2] = 1'b0; en[2] = 1'b1; up_s[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(2, 3, 8'hFF, (i > 0), 1'b1);
            cyc();
        end
        up_s[2] = 1'b0;
        push(2, 3, 8'hFE, 1'b0, 1'b0);
        cyc();
        en[2] = 1'b0;
        push(2, 3, 8'hFE, 1'b0, 1'b0);
        cyc();

        // Test 4: wrap below zero.
        ld[0] = 1'b1; lv[0] = 8'h00; en[0] = 1'b1;
        push(0, 4, 8'h00, 1'b0, 1'b0);
        cyc();
        ld[0] = 1'b0; up_s[0] = 1'b0;
        push(0, 4, 8'hFF, 1'b1, 1'b0);
        cyc();
        en[0] = 1'b0;
        push(0, 4, 8'hFF, 1'b0, 1'b0);
        cyc();

        // Test 5: load beats enable; match only while count equals compare.
        ld[0] = 1'b1; en[0] = 1'b1; up_s[0] = 1'b1; lv[0] = 8'h40; cmp[0] = 8'h42;
        push(0, 5, 8'h40, 1'b0, 1'b0);
        cyc();
        ld[0] = 1'b0;
        push(0, 5, 8'h41, 1'b0, 1'b0);
        cyc();
        push(0, 5, 8'h42, 1'b0, 1'b1);
        cyc();
        push(0, 5, 8'h43, 1'b0, 1'b0);
        cyc();
        en[0] = 1'b0;

        // Test 6: asynchronous reset between edges.
        ld[0] = 1'b1; lv[0] = 8'h37; cmp[0] = 8'h37;
        push(0, 6, 8'h37, 1'b0, 1'b1);
        cyc();
        ld[0] = 1'b0;
        push(0, 6, 8'h37, 1'b0, 1'b1);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async dut%0d count", k), 32'(cnt[k]), 32'h0);
            check($sformatf("async dut%0d terminal", k), 32'(term[k]), 32'h0);
            check($sformatf("async dut%0d match", k), 32'(mt[k]), 32'h0);
        end
        cyc();
        rst = 1'b0; en[0] = 1'b1; up_s[0] = 1'b1;
        check("release count", 32'(cnt[0]), 32'h0);
        push(0, 6, 8'h01, 1'b0, 1'b0);
        cyc();
        push(0, 6, 8'h02, 1'b0, 1'b0);
        cyc();
        en[0] = 1'b0;
        cyc();
        cyc();

        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
